// File: rtl/io_pkg.sv
// Shared I/O bus constants for the io and io_kbd_input blocks.
// Also holds the status-word packing used by the keyboard input port.
package io_pkg;

  localparam logic [15:0] IO_ADDR_PRINTASCII = 16'h0000;
  localparam logic [15:0] IO_ADDR_KBD_DATA   = 16'h0001;
  localparam logic [15:0] IO_ADDR_KBD_STATUS = 16'h0002;

  localparam int STAT_AVAIL   = 0;
  localparam int STAT_FULL    = 1;
  localparam int STAT_OVF     = 2;
  localparam int STAT_CNT_LSB = 8;

  function automatic logic [15:0] make_status(input logic       avail,
                                              input logic       full,
                                              input logic       ovf,
                                              input logic [7:0] cnt);
    logic [15:0] w;
    w = 16'h0000;
    w[STAT_AVAIL] = avail;
    w[STAT_FULL]  = full;
    w[STAT_OVF]   = ovf;
    w[STAT_CNT_LSB +: 8] = cnt;
    return w;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead read data; a push is accepted while full
// when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is deliberately left uninitialised by reset.
  always_ff @(posedge clk) begin
    if (!rst && do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/io_kbd_input.sv
// Memory-mapped character input port: buffers strobed ASCII bytes and lets the
// CPU poll status and pop characters over the shared I/O bus.
module io_kbd_input
  import io_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] addr,
  input  logic [15:0] data,
  input  logic        write,
  input  logic        read,
  output logic [15:0] data_out,
  input  logic [7:0]  kbd_data,
  input  logic        kbd_strobe,
  output logic        kbd_avail
);

  localparam int CW = $clog2(DEPTH) + 1;

  // kbd_strobe is a one-cycle valid with no ready: a byte arriving while the
  // FIFO is full (and nothing is popped that cycle) is lost and flagged.
  logic [7:0]    fifo_rdata;
  logic          fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;
  logic          is_data, is_stat, pop_en, drop;
  logic          ovf_q, ovf_d;
  logic [15:0]   data_out_q, data_out_d;

  assign is_data = (addr == IO_ADDR_KBD_DATA);
  assign is_stat = (addr == IO_ADDR_KBD_STATUS);
  assign pop_en  = read && is_data;
  assign drop    = kbd_strobe && fifo_full && !pop_en;

  sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (kbd_strobe),
    .push_data (kbd_data),
    .pop       (pop_en),
    .pop_data  (fifo_rdata),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_comb begin
    ovf_d = ovf_q;
    if (write && is_stat && data[STAT_OVF]) ovf_d = 1'b0;
    // A drop in the same cycle as a clear leaves the flag set.
    if (drop) ovf_d = 1'b1;
  end

  always_comb begin
    data_out_d = 16'h0000;
    if (read) begin
      if (is_data && !fifo_empty) data_out_d = {8'h00, fifo_rdata};
      else if (is_stat)
        data_out_d = make_status(!fifo_empty, fifo_full, ovf_q, 8'(fifo_count));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q      <= 1'b0;
      data_out_q <= 16'h0000;
    end else begin
      ovf_q      <= ovf_d;
      data_out_q <= data_out_d;
    end
  end

  assign data_out  = data_out_q;
  assign kbd_avail = (fifo_count != '0);

endmodule

// File: tb/tb_io_kbd_input.sv
// Bench for io_kbd_input: a behavioural queue model predicts every data_out
// word, which is queued at drive time and compared the cycle after.
module tb_io_kbd_input;

  localparam int DEPTH = 16;

  logic        clk, rst;
  logic [15:0] addr, data;
  logic        write, read;
  logic [15:0] data_out;
  logic [7:0]  kbd_data;
  logic        kbd_strobe;
  logic        kbd_avail;

  io_kbd_input #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .addr       (addr),
    .data       (data),
    .write      (write),
    .read       (read),
    .data_out   (data_out),
    .kbd_data   (kbd_data),
    .kbd_strobe (kbd_strobe),
    .kbd_avail  (kbd_avail)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard and model
  logic [15:0] exp_q[$];
  logic [7:0]  m_q[$];
  logic        m_ovf;
  int          chk_cnt  = 0;
  int          pass_cnt = 0;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
  endtask

  function automatic logic [15:0] model_read(input logic [15:0] a);
    logic [15:0] w;
    w = 16'h0000;
    if (a == 16'h0001 && m_q.size() != 0) w = {8'h00, m_q[0]};
    else if (a == 16'h0002) begin
      w[0] = (m_q.size() != 0);
      w[1] = (m_q.size() == DEPTH);
      w[2] = m_ovf;
      w[15:8] = 8'(m_q.size());
    end
    return w;
  endfunction

  // driver: one bus cycle; expected data_out is queued now, checked after the edge
  task automatic do_cycle(input logic rd, input logic wr, input logic [15:0] a,
                          input logic [15:0] d, input logic stb, input logic [7:0] ch,
                          input string tag);
    logic [7:0] junk;
    logic       drop;
    read = rd; write = wr; addr = a; data = d; kbd_strobe = stb; kbd_data = ch;
    exp_q.push_back(rd ? model_read(a) : 16'h0000);
    drop = 1'b0;
    if (rd && a == 16'h0001 && m_q.size() != 0) junk = m_q.pop_front();
    if (stb) begin
      if (m_q.size() < DEPTH) m_q.push_back(ch);
      else drop = 1'b1;
    end
    if (wr && a == 16'h0002 && d[2]) m_ovf = 1'b0;
    if (drop) m_ovf = 1'b1;
    @(posedge clk); #1;
    check(tag, data_out, exp_q.pop_front());
    check({tag, "_avail"}, {15'h0, kbd_avail}, {15'h0, (m_q.size() != 0)});
    read = 0; write = 0; kbd_strobe = 0;
  endtask

  task automatic do_rst(input logic stb, input logic rd);
    rst = 1'b1; read = rd; addr = 16'h0001; kbd_strobe = stb; kbd_data = 8'h55;
    exp_q.push_back(16'h0000);
    m_q.delete(); m_ovf = 1'b0;
    @(posedge clk); #1;
    check("rst_data_out", data_out, exp_q.pop_front());
    check("rst_avail", {15'h0, kbd_avail}, 16'h0000);
    rst = 1'b0; read = 0; kbd_strobe = 0;
  endtask

  task automatic strobe(input logic [7:0] ch);
    do_cycle(0, 0, 16'h0000, 16'h0000, 1, ch, "strobe_idle");
  endtask
  task automatic rd_data(input string tag);
    do_cycle(1, 0, 16'h0001, 16'h0000, 0, 8'h00, tag);
  endtask
  task automatic rd_stat(input string tag);
    do_cycle(1, 0, 16'h0002, 16'h0000, 0, 8'h00, tag);
  endtask

  initial begin
    rst = 0; read = 0; write = 0; addr = 0; data = 0; kbd_strobe = 0; kbd_data = 0;
    m_ovf = 1'b0;
    @(posedge clk); #1;

    // 1: reset state
    do_rst(0, 0);
    rd_stat("t1_status");

    // 2: two chars, status, pops, empty pop
    strobe(8'h48); strobe(8'h69);
    rd_stat("t2_status");
    rd_data("t2_pop0"); rd_data("t2_pop1"); rd_data("t2_pop_empty");
    rd_stat("t2_status_empty");

    // 3: overflow with 17 chars, drain, clear
    for (int i = 0; i < 17; i++) strobe(8'(8'h41 + i));
    rd_stat("t3_status_ovf");
    for (int i = 0; i < 16; i++) rd_data("t3_pop");
    do_cycle(0, 1, 16'h0002, 16'h0004, 0, 8'h00, "t3_clear");
    rd_stat("t3_status_clr");

    // 4: full + strobe during pop -> accepted, no overflow
    for (int i = 0; i < 16; i++) strobe(8'(8'h60 + i));
    do_cycle(1, 0, 16'h0001, 16'h0000, 1, 8'h5A, "t4_pop_push");
    rd_stat("t4_status_full");
    for (int i = 0; i < 16; i++) rd_data("t4_pop");

    // 5: empty + strobe with DATA read -> no bypass
    do_cycle(1, 0, 16'h0001, 16'h0000, 1, 8'h31, "t5_nobypass");
    rd_data("t5_pop");

    // status read same cycle as push reports pre-push state
    do_cycle(1, 0, 16'h0002, 16'h0000, 1, 8'h22, "status_prepush");
    rd_stat("status_post");
    rd_data("drain_22");

    // clear racing a dropping strobe: set wins; read+write together on DATA
    for (int i = 0; i < 16; i++) strobe(8'(8'h70 + i));
    do_cycle(0, 1, 16'h0002, 16'h0004, 1, 8'h99, "clr_vs_drop");
    rd_stat("ovf_set_wins");
    do_cycle(1, 1, 16'h0001, 16'h0004, 0, 8'h00, "rdwr_data");
    do_cycle(1, 1, 16'h0002, 16'h0004, 0, 8'h00, "rdwr_status");
    rd_stat("ovf_cleared");
    do_cycle(1, 0, 16'h0003, 16'h0000, 0, 8'h00, "unmapped");

    // 6: reset mid-stream with strobe and read active
    strobe(8'h01); strobe(8'h02); strobe(8'h03);
    do_rst(1, 1);
    rd_stat("t6_status");
    strobe(8'h7A);
    rd_data("t6_pop");

    // random traffic against the model
    for (int i = 0; i < 400; i++) begin
      logic rd, wr, stb;
      logic [15:0] a;
      rd  = ($urandom_range(0, 2) == 0);
      wr  = ($urandom_range(0, 5) == 0);
      stb = ($urandom_range(0, 1) == 1);
      a   = 16'($urandom_range(0, 3));
      do_cycle(rd, wr, a, 16'($urandom_range(0, 65535)), stb,
               8'($urandom_range(0, 255)), "rand");
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
